// File: rtl/dual_diagonal_sched.sv
// Frame-level round-robin scheduler sharing one dual_diagonal_backsub datapath among NUM_REQ requesters.
// Define DUAL_DIAG_SCHED_PRIORITY_EN for strict lowest-index-wins priority instead of round-robin.
module dual_diagonal_sched #(
    parameter int WIDTH     = 8,
    parameter int NUM_WORDS = 1024,
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ*WIDTH-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic [WIDTH-1:0]           o_bs_data,
    output logic                       o_bs_valid,
    input  logic [WIDTH-1:0]           i_bs_data,
    input  logic                       i_bs_valid,
    output logic [WIDTH-1:0]           o_res_data,
    output logic                       o_res_valid,
    output logic [$clog2(NUM_REQ)-1:0] o_res_chan,
    output logic                       o_res_last,
    output logic                       o_res_err
);
    localparam int CW  = $clog2(NUM_REQ);
    localparam int WCW = $clog2(NUM_WORDS);
    localparam int TPW = $clog2(TAG_DEPTH);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE,
        XFER
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   sel;
    logic [CW-1:0]   grant;
    logic            grant_found;
    logic [WCW-1:0]  word_cnt;
    logic [WCW-1:0]  res_cnt;
    logic            start, hs, frame_done;

    logic [CW-1:0]   tag_mem [TAG_DEPTH];
    logic [TPW-1:0]  tag_wr, tag_rd;
    logic [TPW:0]    tag_cnt;
    logic            tag_full, tag_empty, tag_push, tag_pop;

    assign tag_full   = (tag_cnt == (TPW+1)'(TAG_DEPTH));
    assign tag_empty  = (tag_cnt == '0);
    assign start      = (state == IDLE) && grant_found && !tag_full;
    assign hs         = (state == XFER) && i_req_valid[sel];
    assign frame_done = hs && (word_cnt == LAST_WORD);
    assign tag_push   = start;
    assign tag_pop    = i_bs_valid && (res_cnt == LAST_WORD) && !tag_empty;

`ifdef DUAL_DIAG_SCHED_PRIORITY_EN
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && i_req_valid[CW'(i)]) begin
                grant       = CW'(i);
                grant_found = 1'b1;
            end
        end
    end
`else
    logic [CW-1:0] last_grant;
    int unsigned   rr_idx;

    // Circular search starting one past the previous grant.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        rr_idx      = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            rr_idx = i + 32'(last_grant);
            if (rr_idx >= NUM_REQ)
                rr_idx = rr_idx - NUM_REQ;
            if (!grant_found && i_req_valid[CW'(rr_idx)]) begin
                grant       = CW'(rr_idx);
                grant_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            last_grant <= CW'(NUM_REQ - 1);
        else if (frame_done)
            last_grant <= sel;
    end
`endif

    always_comb begin
        state_next  = state;
        o_req_ready = '0;
        unique case (state)
            IDLE: if (start) state_next = XFER;
            XFER: begin
                o_req_ready[sel] = 1'b1;
                if (frame_done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            sel      <= '0;
            word_cnt <= '0;
        end else begin
            state <= state_next;
            if (start)
                sel <= grant;
            if (start || frame_done)
                word_cnt <= '0;
            else if (hs)
                word_cnt <= word_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            o_bs_valid <= 1'b0;
            o_bs_data  <= '0;
        end else begin
            o_bs_valid <= hs;
            if (hs)
                o_bs_data <= i_req_data[sel*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clock) begin
        if (tag_push)
            tag_mem[tag_wr] <= grant;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tag_wr  <= '0;
            tag_rd  <= '0;
            tag_cnt <= '0;
        end else begin
            if (tag_push) tag_wr <= tag_wr + 1'b1;
            if (tag_pop)  tag_rd <= tag_rd + 1'b1;
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt <= tag_cnt + 1'b1;
                2'b01:   tag_cnt <= tag_cnt - 1'b1;
                default: tag_cnt <= tag_cnt;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            res_cnt     <= '0;
            o_res_data  <= '0;
            o_res_valid <= 1'b0;
            o_res_chan  <= '0;
            o_res_last  <= 1'b0;
            o_res_err   <= 1'b0;
        end else begin
            o_res_data  <= i_bs_data;
            o_res_valid <= i_bs_valid;
            o_res_chan  <= tag_empty ? '0 : tag_mem[tag_rd];
            o_res_last  <= i_bs_valid && (res_cnt == LAST_WORD);
            if (i_bs_valid)
                res_cnt <= (res_cnt == LAST_WORD) ? '0 : res_cnt + 1'b1;
            if (i_bs_valid && tag_empty)
                o_res_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dual_diagonal_sched.sv
// Directed bench for dual_diagonal_sched: frame grants, round-robin order, gaps, tag FIFO full, errors, reset.
module tb_dual_diagonal_sched;
    localparam int W  = 8;
    localparam int NW = 1024;
    localparam int NR = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [NR*W-1:0] req_data = '0;
    logic [NR-1:0]  req_valid = '0;
    logic [NR-1:0]  o_req_ready;
    logic [W-1:0]   o_bs_data;
    logic           o_bs_valid;
    logic [W-1:0]   bs_data_in;
    logic           bs_valid_in;
    logic [W-1:0]   o_res_data;
    logic           o_res_valid;
    logic [1:0]     o_res_chan;
    logic           o_res_last;
    logic           o_res_err;

    logic           loopback = 1'b0;
    logic           bs_valid_drv = 1'b0;
    logic [W-1:0]   bs_data_drv = '0;

    assign bs_valid_in = loopback ? o_bs_valid : bs_valid_drv;
    assign bs_data_in  = loopback ? o_bs_data  : bs_data_drv;

    dual_diagonal_sched #(.WIDTH(W), .NUM_WORDS(NW), .NUM_REQ(NR), .TAG_DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .i_req_data  (req_data),
        .i_req_valid (req_valid),
        .o_req_ready (o_req_ready),
        .o_bs_data   (o_bs_data),
        .o_bs_valid  (o_bs_valid),
        .i_bs_data   (bs_data_in),
        .i_bs_valid  (bs_valid_in),
        .o_res_data  (o_res_data),
        .o_res_valid (o_res_valid),
        .o_res_chan  (o_res_chan),
        .o_res_last  (o_res_last),
        .o_res_err   (o_res_err)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Requester sources: budget = frames still to send, sent = words accepted so far.
    int sent   [NR];
    int budget [NR];
    int gap_req = -1, gap_word = 0, gap_left = 0;

    always @(posedge clock) begin
        for (int r = 0; r < NR; r++) begin
            if (req_valid[r] && o_req_ready[r]) begin
                sent[r]++;
                if (sent[r] % NW == 0) budget[r]--;
            end
        end
    end

    always @(negedge clock) begin
        for (int r = 0; r < NR; r++) begin
            if (budget[r] > 0) begin
                if (r == gap_req && sent[r] == gap_word && gap_left > 0) begin
                    req_valid[r] = 1'b0;
                    gap_left--;
                end else begin
                    req_valid[r] = 1'b1;
                end
            end else begin
                req_valid[r] = 1'b0;
            end
            req_data[r*W +: W] = sent[r][W-1:0];
        end
    end

    // Output monitor
    int bs_cnt, bs_bad, bs_seq, res_words, res_in, frame_chan, chan_bad, idle_run, had_grant;
    logic [NR-1:0] prev_ready;
    int grant_q[$], idle_q[$], res_chan_q[$], res_len_q[$];

    task automatic clear_mon();
        bs_cnt = 0; bs_bad = 0; bs_seq = 0; res_words = 0; res_in = 0; frame_chan = 0;
        chan_bad = 0; idle_run = 0; had_grant = 0; prev_ready = '0;
        grant_q.delete(); idle_q.delete(); res_chan_q.delete(); res_len_q.delete();
    endtask

    always @(negedge clock) begin
        if (o_bs_valid) begin
            if (o_bs_data !== bs_seq[W-1:0]) bs_bad++;
            bs_seq = (bs_seq == NW - 1) ? 0 : bs_seq + 1;
            bs_cnt++;
        end
        if (o_res_valid) begin
            res_words++;
            if (res_in == 0) frame_chan = int'(o_res_chan);
            else if (int'(o_res_chan) != frame_chan) chan_bad++;
            res_in++;
            if (o_res_last) begin
                res_chan_q.push_back(frame_chan);
                res_len_q.push_back(res_in);
                res_in = 0;
            end
        end
        if (o_req_ready != '0 && prev_ready == '0) begin
            for (int r = 0; r < NR; r++)
                if (o_req_ready[r]) grant_q.push_back(r);
            if (had_grant != 0) idle_q.push_back(idle_run);
            had_grant = 1;
        end
        if (o_req_ready == '0) idle_run++;
        else idle_run = 0;
        prev_ready = o_req_ready;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
        #1;
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        loopback = 1'b0;
        bs_valid_drv = 1'b0;
        gap_req = -1;
        for (int r = 0; r < NR; r++) begin
            budget[r] = 0;
            sent[r]   = 0;
        end
        tick(2);
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_ready"},    32'(o_req_ready), 0);
        check({pfx, "_bs_valid"}, 32'(o_bs_valid),  0);
        check({pfx, "_bs_data"},  32'(o_bs_data),   0);
        check({pfx, "_res_valid"},32'(o_res_valid), 0);
        check({pfx, "_res_data"}, 32'(o_res_data),  0);
        check({pfx, "_res_chan"}, 32'(o_res_chan),  0);
        check({pfx, "_res_last"}, 32'(o_res_last),  0);
        check({pfx, "_res_err"},  32'(o_res_err),   0);
    endtask

    task automatic wait_frames(input string tag, input int n, input int limit);
        int c = 0;
        while (res_chan_q.size() < n && c < limit) begin
            tick(1);
            c++;
        end
        check(tag, res_chan_q.size(), n);
    endtask

    initial begin
        int c;
        int nz;
        int exp_pri[4];

        // Reset state and single frame from requester 2
        do_reset();
        check_reset_outputs("rst");
        loopback = 1'b1;
        budget[2] = 1;
        tick(1);
        check("t1_ready_idle", 32'(o_req_ready), 0);
        tick(1);
        check("t1_ready_grant", 32'(o_req_ready), 32'b0100);
        tick(1);
        check("t1_bs_first_valid", 32'(o_bs_valid), 1);
        check("t1_bs_first_data",  32'(o_bs_data),  0);
        wait_frames("t1_done", 1, 3000);
        check("t1_bs_cnt",   bs_cnt, NW);
        check("t1_bs_bad",   bs_bad, 0);
        check("t1_res_words",res_words, NW);
        check("t1_chan",     q_at(res_chan_q, 0), 2);
        check("t1_len",      q_at(res_len_q, 0), NW);
        check("t1_chan_bad", chan_bad, 0);

        // Round-robin with all four valid
        do_reset();
        loopback = 1'b1;
        budget[0] = 2; budget[1] = 1; budget[2] = 1; budget[3] = 1;
        wait_frames("t2_done", 5, 8000);
        check("t2_grants", grant_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_grant%0d", i), q_at(grant_q, i), i % 4);
            check($sformatf("t2_chan%0d", i),  q_at(res_chan_q, i), i % 4);
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("t2_idle%0d", i), q_at(idle_q, i), 1);
        check("t2_bs_bad",   bs_bad, 0);
        check("t2_chan_bad", chan_bad, 0);

        // Valid gap on requester 1 while 3 waits
        do_reset();
        loopback = 1'b1;
        gap_req = 1; gap_word = 500; gap_left = 5;
        budget[1] = 1; budget[3] = 1;
        c = 0;
        while (sent[1] < 500 && c < 3000) begin
            tick(1);
            c++;
        end
        check("t3_reach500", 32'(sent[1]), 500);
        tick(2);
        check("t3_gap_ready", 32'(o_req_ready), 32'b0010);
        check("t3_gap_bs",    32'(o_bs_valid), 0);
        check("t3_gap_sent",  32'(sent[1]), 500);
        wait_frames("t3_done", 2, 5000);
        check("t3_grant0", q_at(grant_q, 0), 1);
        check("t3_grant1", q_at(grant_q, 1), 3);
        check("t3_len0",   q_at(res_len_q, 0), NW);
        check("t3_chan0",  q_at(res_chan_q, 0), 1);
        check("t3_chan1",  q_at(res_chan_q, 1), 3);
        check("t3_bs_bad", bs_bad, 0);

        // Tag FIFO full blocks a fifth grant until a result frame pops
        do_reset();
        budget[0] = 2; budget[1] = 1; budget[2] = 1; budget[3] = 1;
        c = 0;
        while (bs_cnt < 4 * NW && c < 6000) begin
            tick(1);
            c++;
        end
        check("t4_bs_cnt", bs_cnt, 4 * NW);
        nz = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (o_req_ready != '0) nz++;
        end
        check("t4_blocked", nz, 0);
        check("t4_grants4", grant_q.size(), 4);
        for (int i = 0; i < NW; i++) begin
            bs_valid_drv = 1'b1;
            bs_data_drv  = i[W-1:0];
            tick(1);
        end
        bs_valid_drv = 1'b0;
        check("t4_last",        32'(o_res_last), 1);
        check("t4_last_chan",   32'(o_res_chan), 0);
        check("t4_ready_still0",32'(o_req_ready), 0);
        tick(1);
        check("t4_grant5",      32'(o_req_ready), 32'b0001);
        check("t4_res_len",     q_at(res_len_q, 0), NW);
        check("t4_err",         32'(o_res_err), 0);

        // Result with no frame in flight sets a sticky error
        do_reset();
        bs_valid_drv = 1'b1;
        bs_data_drv  = 8'hA5;
        tick(1);
        bs_valid_drv = 1'b0;
        check("t5_err",       32'(o_res_err),   1);
        check("t5_res_valid", 32'(o_res_valid), 1);
        check("t5_res_data",  32'(o_res_data),  32'hA5);
        check("t5_res_chan",  32'(o_res_chan),  0);
        tick(5);
        check("t5_err_sticky", 32'(o_res_err),  1);

        // Reset mid-frame: frame 0 done, frame 1 aborted at word 300
        do_reset();
        check("t6_err_cleared", 32'(o_res_err), 0);
        loopback = 1'b1;
        budget[0] = 1; budget[1] = 1;
        c = 0;
        while (sent[1] < 300 && c < 4000) begin
            tick(1);
            c++;
        end
        check("t6_reach300", 32'(sent[1]), 300);
        reset = 1'b1;
        tick(1);
        check_reset_outputs("t6");
        for (int r = 0; r < NR; r++) begin
            budget[r] = 0;
            sent[r]   = 0;
        end
        tick(1);
        reset = 1'b0;
        clear_mon();
        budget[0] = 1; budget[2] = 1;
        wait_frames("t6_done", 2, 4000);
        check("t6_grant0", q_at(grant_q, 0), 0);
        check("t6_grant1", q_at(grant_q, 1), 2);

        // Arbitration policy with requesters 0 and 3 continuously valid
        do_reset();
        loopback = 1'b1;
        budget[0] = 3; budget[3] = 1;
`ifdef DUAL_DIAG_SCHED_PRIORITY_EN
        exp_pri = '{0, 0, 0, 3};
`else
        exp_pri = '{0, 3, 0, 0};
`endif
        wait_frames("t7_done", 4, 8000);
        for (int i = 0; i < 4; i++)
            check($sformatf("t7_grant%0d", i), q_at(grant_q, i), exp_pri[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
